pc_gen: RTL

//  Parametrised program-counter generator at the head of the IF stage; drives the fetch address into IF_ID.

---
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch-address interface between the IF-stage PC generator and its
// control sources (hazard unit, trap logic, branch resolution, call/return).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_vec_i;
    logic            br_taken_i;
    logic [XLEN-1:0] br_target_i;
    logic            ras_push_i;
    logic [XLEN-1:0] ras_data_i;
    logic            ret_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_next_o;
    logic            valid_o;
    logic            misalign_o;
    logic            ras_empty_o;
    logic            ras_uflow_o;

    // Request side: pipeline control that steers the PC.
    modport master (
        output stall_i, trap_i, trap_vec_i, br_taken_i, br_target_i,
               ras_push_i, ras_data_i, ret_i,
        input  pc_o, pc_next_o, valid_o, misalign_o, ras_empty_o, ras_uflow_o
    );

    // PC generator side.
    modport slave (
        input  stall_i, trap_i, trap_vec_i, br_taken_i, br_target_i,
               ras_push_i, ras_data_i, ret_i,
        output pc_o, pc_next_o, valid_o, misalign_o, ras_empty_o, ras_uflow_o
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage. Priority redirect selection
// (trap > branch > return > deferred > sequential), stall-safe capture of
// redirects into a single pending slot, and a circular return-address stack.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INCR         = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input logic   clk,
    input logic   rst,
    pc_gen_if.slave bus
);
    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] INCR_V     = XLEN'(INCR);
    localparam logic [XLEN-1:0] LOW_MASK   = INCR_V - 1'b1;
    localparam logic [CW-1:0]   DEPTH_V    = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            misalign_q;
    logic            pend_q;
    logic            pend_trap_q;
    logic            pend_mis_q;
    logic [XLEN-1:0] pend_tgt_q;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            uflow_q;

    logic [PW-1:0]   ptr_m1;
    logic            ras_empty;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] ret_tgt;
    logic            req;
    logic [XLEN-1:0] req_raw;
    logic            req_mis;

    // Request selection and return target lookup.
    always_comb begin
        ptr_m1    = ptr_q - 1'b1;
        ras_empty = (cnt_q == '0);
        pc_inc    = pc_q + INCR_V;
        ret_tgt   = ras_empty ? pc_inc : ras_q[ptr_m1];
        req       = bus.trap_i | bus.br_taken_i | bus.ret_i;
        if (bus.trap_i) begin
            req_raw = bus.trap_vec_i;
        end else if (bus.br_taken_i) begin
            req_raw = bus.br_target_i;
        end else begin
            req_raw = ret_tgt;
        end
        req_mis = |(req_raw & LOW_MASK);
    end

    // PC register, pending redirect slot and the misalign pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_mis_q  <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            valid_q    <= 1'b1;
            misalign_q <= 1'b0;
            if (!bus.stall_i) begin
                pend_q      <= 1'b0;
                pend_trap_q <= 1'b0;
                pend_mis_q  <= 1'b0;
                if (req) begin
                    pc_q       <= req_raw & ~LOW_MASK;
                    misalign_q <= req_mis;
                end else if (pend_q) begin
                    pc_q       <= pend_tgt_q;
                    misalign_q <= pend_mis_q;
                end else begin
                    pc_q <= pc_inc;
                end
            end else if (req && (bus.trap_i || !(pend_q && pend_trap_q))) begin
                // A pending trap is only displaced by a newer trap.
                pend_q      <= 1'b1;
                pend_trap_q <= bus.trap_i;
                pend_mis_q  <= req_mis;
                pend_tgt_q  <= req_raw & ~LOW_MASK;
            end
        end
    end

    // Return-address stack; operates every cycle, independent of stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            ptr_q   <= '0;
            cnt_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= bus.ret_i && ras_empty;
            if (bus.ret_i && !ras_empty) begin
                if (bus.ras_push_i) begin
                    ras_q[ptr_m1] <= bus.ras_data_i;
                end else begin
                    ptr_q <= ptr_m1;
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (bus.ras_push_i) begin
                ras_q[ptr_q] <= bus.ras_data_i;
                ptr_q        <= ptr_q + 1'b1;
                if (cnt_q != DEPTH_V) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.pc_o        = pc_q;
    assign bus.pc_next_o   = pc_inc;
    assign bus.valid_o     = valid_q;
    assign bus.misalign_o  = misalign_q;
    assign bus.ras_empty_o = ras_empty;
    assign bus.ras_uflow_o = uflow_q;
endmodule
